// File: rtl/arch_defs_pkg.sv
// Shared architecture definitions: address width, branch opcodes and
// the branch unit's control states.
package arch_defs_pkg;

  localparam int ADDR_WIDTH = 16;

  typedef enum logic [2:0] {
    BR_JMP  = 3'd0,
    BR_JZ   = 3'd1,
    BR_JNZ  = 3'd2,
    BR_JN   = 3'd3,
    BR_JC   = 3'd4,
    BR_JNC  = 3'd5,
    BR_CALL = 3'd6,
    BR_RET  = 3'd7
  } br_op_t;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_EVAL   = 2'd1,
    ST_COMMIT = 2'd2
  } br_state_t;

endpackage

// File: rtl/return_stack.sv
// LIFO of return addresses. data_o always shows the top entry; a push
// while full or a pop while empty is ignored (the caller flags the error).
module return_stack #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic [WIDTH-1:0]         data_i,
  output logic [WIDTH-1:0]         data_o,
  output logic [$clog2(DEPTH):0]   depth_o,
  output logic                     full_o,
  output logic                     empty_o
);

  localparam int IW = $clog2(DEPTH);
  localparam int DW = IW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [DW-1:0]    depth_q, depth_d;
  logic [IW-1:0]    wr_idx, top_idx;

  assign full_o  = (depth_q == DW'(DEPTH));
  assign empty_o = (depth_q == '0);
  assign depth_o = depth_q;

  // Power-of-two depth lets the low bits index the array directly.
  assign wr_idx  = depth_q[IW-1:0];
  assign top_idx = depth_q[IW-1:0] - IW'(1);
  assign data_o  = mem_q[top_idx];

  always_comb begin
    depth_d = depth_q;
    if (push_i && !full_o) begin
      depth_d = depth_q + DW'(1);
    end else if (pop_i && !empty_o) begin
      depth_d = depth_q - DW'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      depth_q <= '0;
    end else begin
      depth_q <= depth_d;
    end
  end

  // Contents are left untouched by reset; only the depth is cleared.
  always_ff @(posedge clk) begin
    if (push_i && !full_o) begin
      mem_q[wr_idx] <= data_i;
    end
  end

endmodule

// File: rtl/pc_branch_unit.sv
// Program counter with a three-state branch sequencer (IDLE/EVAL/COMMIT),
// conditional jumps on captured flags, and CALL/RET through a return stack.
module pc_branch_unit #(
  parameter int ADDR_WIDTH  = arch_defs_pkg::ADDR_WIDTH,
  parameter int STACK_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          pc_inc_i,
  input  logic                          br_req_i,
  input  logic [2:0]                    br_op_i,
  input  logic [ADDR_WIDTH-1:0]         br_target_i,
  input  logic                          flag_zero_i,
  input  logic                          flag_negative_i,
  input  logic                          flag_carry_i,
  output logic [ADDR_WIDTH-1:0]         pc_o,
  output logic                          busy_o,
  output logic                          br_done_o,
  output logic                          br_taken_o,
  output logic [$clog2(STACK_DEPTH):0]  stack_depth_o,
  output logic                          stack_overflow_o,
  output logic                          stack_underflow_o
);

  import arch_defs_pkg::*;

  br_state_t             state_q, state_d;
  br_op_t                op_q, op_d;
  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  logic [ADDR_WIDTH-1:0] target_q, target_d;
  logic [ADDR_WIDTH-1:0] cap_pc_q, cap_pc_d;
  logic                  z_q, z_d, n_q, n_d, c_q, c_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  taken_q, taken_d;
  logic                  ovf_q, ovf_d;
  logic                  unf_q, unf_d;

  logic                  cond;
  logic                  push, pop;
  logic                  stk_full, stk_empty;
  logic [ADDR_WIDTH-1:0] stk_top;

  return_stack #(
    .WIDTH (ADDR_WIDTH),
    .DEPTH (STACK_DEPTH)
  ) u_return_stack (
    .clk     (clk),
    .reset   (reset),
    .push_i  (push),
    .pop_i   (pop),
    .data_i  (cap_pc_q),
    .data_o  (stk_top),
    .depth_o (stack_depth_o),
    .full_o  (stk_full),
    .empty_o (stk_empty)
  );

  always_comb begin
    unique case (op_q)
      BR_JZ:   cond = z_q;
      BR_JNZ:  cond = !z_q;
      BR_JN:   cond = n_q;
      BR_JC:   cond = c_q;
      BR_JNC:  cond = !c_q;
      default: cond = 1'b1;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    pc_d     = pc_q;
    target_d = target_q;
    cap_pc_d = cap_pc_q;
    z_d      = z_q;
    n_d      = n_q;
    c_d      = c_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    taken_d  = 1'b0;
    ovf_d    = ovf_q;
    unf_d    = unf_q;
    push     = 1'b0;
    pop      = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (br_req_i) begin
          state_d  = ST_EVAL;
          busy_d   = 1'b1;
          op_d     = br_op_t'(br_op_i);
          target_d = br_target_i;
          cap_pc_d = pc_q;
          z_d      = flag_zero_i;
          n_d      = flag_negative_i;
          c_d      = flag_carry_i;
        end else if (pc_inc_i) begin
          pc_d = pc_q + ADDR_WIDTH'(1);
        end
      end
      ST_EVAL: begin
        // Stack depth is stable until COMMIT, so the outcome is final here.
        state_d = ST_COMMIT;
        done_d  = 1'b1;
        taken_d = cond && !(op_q == BR_CALL && stk_full)
                       && !(op_q == BR_RET && stk_empty);
      end
      ST_COMMIT: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
        if (taken_q) begin
          if (op_q == BR_RET) begin
            pc_d = stk_top;
            pop  = 1'b1;
          end else begin
            pc_d = target_q;
            push = (op_q == BR_CALL);
          end
        end
        if (op_q == BR_CALL && stk_full) ovf_d = 1'b1;
        if (op_q == BR_RET && stk_empty) unf_d = 1'b1;
      end
      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      op_q     <= BR_JMP;
      pc_q     <= '0;
      target_q <= '0;
      cap_pc_q <= '0;
      z_q      <= 1'b0;
      n_q      <= 1'b0;
      c_q      <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      taken_q  <= 1'b0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      pc_q     <= pc_d;
      target_q <= target_d;
      cap_pc_q <= cap_pc_d;
      z_q      <= z_d;
      n_q      <= n_d;
      c_q      <= c_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      taken_q  <= taken_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
    end
  end

  assign pc_o              = pc_q;
  assign busy_o            = busy_q;
  assign br_done_o         = done_q;
  assign br_taken_o        = taken_q;
  assign stack_overflow_o  = ovf_q;
  assign stack_underflow_o = unf_q;

endmodule

// File: tb/tb_pc_branch_unit.sv
// Self-checking bench for pc_branch_unit: branch outcomes are queued when a
// request is driven and compared when br_done_o appears.
module tb_pc_branch_unit;
  import arch_defs_pkg::*;

  localparam int AW = 16;
  localparam int SD = 4;
  localparam int DW = $clog2(SD) + 1;

  logic          clk = 1'b0;
  logic          reset;
  logic          pc_inc_i;
  logic          br_req_i;
  logic [2:0]    br_op_i;
  logic [AW-1:0] br_target_i;
  logic          flag_zero_i, flag_negative_i, flag_carry_i;
  logic [AW-1:0] pc_o;
  logic          busy_o, br_done_o, br_taken_o;
  logic [DW-1:0] stack_depth_o;
  logic          stack_overflow_o, stack_underflow_o;

  typedef struct {
    logic          taken;
    logic [AW-1:0] pc;
  } exp_t;

  exp_t          sb_q[$];
  logic [AW-1:0] model_stack[$];
  logic [AW-1:0] model_pc;
  logic          exp_ovf, exp_unf;
  int            n_checks = 0;
  int            n_fail   = 0;

  always #5 clk = ~clk;

  pc_branch_unit #(.ADDR_WIDTH(AW), .STACK_DEPTH(SD)) dut (
    .clk               (clk),
    .reset             (reset),
    .pc_inc_i          (pc_inc_i),
    .br_req_i          (br_req_i),
    .br_op_i           (br_op_i),
    .br_target_i       (br_target_i),
    .flag_zero_i       (flag_zero_i),
    .flag_negative_i   (flag_negative_i),
    .flag_carry_i      (flag_carry_i),
    .pc_o              (pc_o),
    .busy_o            (busy_o),
    .br_done_o         (br_done_o),
    .br_taken_o        (br_taken_o),
    .stack_depth_o     (stack_depth_o),
    .stack_overflow_o  (stack_overflow_o),
    .stack_underflow_o (stack_underflow_o)
  );

  // Called at a negedge; returns at the negedge after the new PC is visible.
  // With junk=1, a second request and pc_inc_i are held high while busy.
  task automatic do_branch(input br_op_t op, input logic [AW-1:0] tgt, input bit junk);
    exp_t e;
    int   cyc;
    logic c, sz, sn, sc;
    case (op)
      BR_JZ:   c = flag_zero_i;
      BR_JNZ:  c = !flag_zero_i;
      BR_JN:   c = flag_negative_i;
      BR_JC:   c = flag_carry_i;
      BR_JNC:  c = !flag_carry_i;
      default: c = 1'b1;
    endcase
    e.taken = c;
    e.pc    = model_pc;
    if (op == BR_CALL && model_stack.size() == SD) begin
      e.taken = 1'b0;
      exp_ovf = 1'b1;
    end else if (op == BR_RET && model_stack.size() == 0) begin
      e.taken = 1'b0;
      exp_unf = 1'b1;
    end
    if (e.taken) begin
      if (op == BR_RET) begin
        e.pc = model_stack.pop_back();
      end else begin
        if (op == BR_CALL) model_stack.push_back(model_pc);
        e.pc = tgt;
      end
    end
    sb_q.push_back(e);

    br_req_i    = 1'b1;
    br_op_i     = op;
    br_target_i = tgt;
    @(negedge clk);
    sz = flag_zero_i; sn = flag_negative_i; sc = flag_carry_i;
    flag_zero_i     = ~sz;
    flag_negative_i = ~sn;
    flag_carry_i    = ~sc;
    br_req_i    = junk;
    pc_inc_i    = junk;
    br_op_i     = BR_JMP;
    br_target_i = 16'hDEAD;
    n_checks++;
    if (busy_o !== 1'b1) begin
      n_fail++;
      $display("FAIL busy_in_eval op=%0d: got %b expected 1", op, busy_o);
    end
    cyc = 1;
    while (br_done_o !== 1'b1 && cyc < 6) begin
      @(negedge clk);
      cyc++;
    end
    br_req_i = 1'b0;
    pc_inc_i = 1'b0;
    flag_zero_i = sz; flag_negative_i = sn; flag_carry_i = sc;
    n_checks++;
    if (br_done_o !== 1'b1) begin
      n_fail++;
      $display("FAIL done_timeout op=%0d: no br_done_o within %0d cycles", op, cyc);
      e = sb_q.pop_front();
    end else begin
      e = sb_q.pop_front();
      n_checks++;
      if (br_taken_o !== e.taken) begin
        n_fail++;
        $display("FAIL taken op=%0d tgt=%h: got %b expected %b", op, tgt, br_taken_o, e.taken);
      end
      n_checks++;
      if (cyc != 2) begin
        n_fail++;
        $display("FAIL done_latency op=%0d: got %0d cycles expected 2", op, cyc);
      end
    end
    @(negedge clk);
    n_checks++;
    if (pc_o !== e.pc || br_done_o !== 1'b0 || busy_o !== 1'b0) begin
      n_fail++;
      $display("FAIL post_commit op=%0d: got pc=%h done=%b busy=%b expected pc=%h done=0 busy=0",
               op, pc_o, br_done_o, busy_o, e.pc);
    end
    n_checks++;
    if (stack_depth_o !== DW'(model_stack.size()) || stack_overflow_o !== exp_ovf
        || stack_underflow_o !== exp_unf) begin
      n_fail++;
      $display("FAIL stack_state op=%0d: got depth=%0d ovf=%b unf=%b expected depth=%0d ovf=%b unf=%b",
               op, stack_depth_o, stack_overflow_o, stack_underflow_o,
               model_stack.size(), exp_ovf, exp_unf);
    end
    model_pc = e.pc;
  endtask

  task automatic do_inc(input int n);
    repeat (n) begin
      pc_inc_i = 1'b1;
      @(negedge clk);
      pc_inc_i = 1'b0;
      model_pc = model_pc + AW'(1);
    end
  endtask

  task automatic check_pc(input string name, input logic [AW-1:0] want);
    n_checks++;
    if (pc_o !== want) begin
      n_fail++;
      $display("FAIL %s: got pc=%h expected %h", name, pc_o, want);
    end
  endtask

  task automatic test_reset();
    n_checks++;
    if (pc_o !== '0 || busy_o !== 1'b0 || br_done_o !== 1'b0 || br_taken_o !== 1'b0
        || stack_depth_o !== '0 || stack_overflow_o !== 1'b0 || stack_underflow_o !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_state: got pc=%h busy=%b done=%b taken=%b depth=%0d ovf=%b unf=%b expected all 0",
               pc_o, busy_o, br_done_o, br_taken_o, stack_depth_o, stack_overflow_o, stack_underflow_o);
    end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_pc_inc();
    do_inc(3);
    check_pc("inc_x3", 16'h0003);
  endtask

  task automatic test_cond_branch();
    flag_zero_i = 1'b0; flag_negative_i = 1'b1; flag_carry_i = 1'b0;
    do_branch(BR_JC, 16'h0040, 1'b0);
    check_pc("jc_not_taken", 16'h0003);
    do_branch(BR_JN, 16'h0040, 1'b0);
    check_pc("jn_taken", 16'h0040);
    do_branch(BR_JZ, 16'h0055, 1'b0);
    do_branch(BR_JNZ, 16'h0050, 1'b1);
    do_branch(BR_JNC, 16'h0060, 1'b0);
    check_pc("jnc_taken", 16'h0060);
  endtask

  task automatic test_call_ret();
    do_branch(BR_JMP, 16'h0010, 1'b0);
    do_branch(BR_CALL, 16'h0100, 1'b0);
    check_pc("call", 16'h0100);
    do_branch(BR_RET, 16'h0000, 1'b0);
    check_pc("ret", 16'h0010);
  endtask

  task automatic test_stack_limits();
    for (int i = 0; i < SD; i++) do_branch(BR_CALL, AW'(16'h0200 + i), i[0]);
    do_branch(BR_CALL, 16'h0300, 1'b0);
    check_pc("call_overflow", 16'h0203);
    for (int i = 0; i < SD; i++) do_branch(BR_RET, 16'h0000, i[0]);
    check_pc("ret_unwind", 16'h0010);
    do_branch(BR_RET, 16'h0000, 1'b0);
    check_pc("ret_underflow", 16'h0010);
  endtask

  task automatic test_wrap();
    do_branch(BR_JMP, 16'hFFFF, 1'b0);
    do_inc(1);
    check_pc("wrap", 16'h0000);
    flag_carry_i = 1'b0;
    pc_inc_i = 1'b1;
    do_branch(BR_JC, 16'h0020, 1'b0);
    check_pc("inc_with_req_dropped", 16'h0000);
  endtask

  task automatic test_back_to_back();
    do_branch(BR_JMP, 16'h1234, 1'b1);
    do_branch(BR_CALL, 16'h2000, 1'b1);
    do_branch(BR_RET, 16'h0000, 1'b1);
    check_pc("back_to_back", 16'h1234);
  endtask

  task automatic test_reset_in_eval();
    br_req_i = 1'b1; br_op_i = BR_JMP; br_target_i = 16'h0077;
    @(negedge clk);
    br_req_i = 1'b0;
    #1 reset = 1'b1;
    #1;
    n_checks++;
    if (pc_o !== '0 || busy_o !== 1'b0 || stack_depth_o !== '0
        || stack_overflow_o !== 1'b0 || stack_underflow_o !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_in_eval: got pc=%h busy=%b depth=%0d ovf=%b unf=%b expected all 0",
               pc_o, busy_o, stack_depth_o, stack_overflow_o, stack_underflow_o);
    end
    @(negedge clk);
    reset = 1'b0;
    model_pc = '0;
    model_stack.delete();
    exp_ovf = 1'b0;
    exp_unf = 1'b0;
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (br_done_o !== 1'b0 || pc_o !== '0) begin
        n_fail++;
        $display("FAIL no_done_after_reset cycle %0d: got done=%b pc=%h expected done=0 pc=0000",
                 i, br_done_o, pc_o);
      end
      @(negedge clk);
    end
  endtask

  initial begin
    reset = 1'b1;
    pc_inc_i = 1'b0; br_req_i = 1'b0; br_op_i = '0; br_target_i = '0;
    flag_zero_i = 1'b0; flag_negative_i = 1'b0; flag_carry_i = 1'b0;
    model_pc = '0;
    exp_ovf = 1'b0;
    exp_unf = 1'b0;
    repeat (2) @(negedge clk);
    test_reset();
    test_pc_inc();
    test_cond_branch();
    test_call_ret();
    test_stack_limits();
    test_wrap();
    test_back_to_back();
    test_reset_in_eval();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pc_branch_unit.md
PC_BRANCH_UNIT -- requirements
Module: pc_branch_unit

Interface
REQ-001 SHALL have parameters, one per line:
- ADDR_WIDTH, 16, program-counter and target width.
- STACK_DEPTH, 4, return-stack entries (power of two, >=2).

REQ-002 SHALL have ports, one per line:
- clk  input  1  single clock; all state on its rising edge.
- reset  input  1  asynchronous, active-high reset.
- pc_inc_i  input  1  advance PC by one.
- br_req_i  input  1  branch/call/return request, one-cycle strobe.
- br_op_i  input  3  operation, br_op_t.
- br_target_i  input  ADDR_WIDTH  jump/call destination.
- flag_zero_i  input  1  Z flag from the flags register.
- flag_negative_i  input  1  N flag.
- flag_carry_i  input  1  C flag (1 = no borrow on subtract/compare).
- pc_o  output  ADDR_WIDTH  current program counter.
- busy_o  output  1  request in flight.
- br_done_o  output  1  one-cycle completion pulse.
- br_taken_o  output  1  PC redirected; valid with br_done_o.
- stack_depth_o  output  $clog2(STACK_DEPTH)+1  occupied return-stack entries.
- stack_overflow_o  output  1  sticky error.
- stack_underflow_o  output  1  sticky error.

Function
REQ-003 SHALL run an FSM with states IDLE, EVAL and COMMIT; IDLE -> EVAL on br_req_i, EVAL -> COMMIT unconditionally, COMMIT -> IDLE unconditionally.
REQ-004 SHALL, on accepting br_req_i in IDLE, capture br_op_i, br_target_i, the three flags and pc_o; later input changes SHALL NOT affect the result.
REQ-005 SHALL assert busy_o in EVAL and COMMIT, and SHALL ignore br_req_i while busy_o=1.
REQ-006 SHALL, in EVAL, resolve the condition:
- JMP, CALL, RET: always.
- JZ: Z=1. JNZ: Z=0.
- JN: N=1.
- JC: C=1. JNC: C=0.
REQ-007 SHALL, in COMMIT, load the captured target into pc_o when the condition is true and the op is not RET.
REQ-008 SHALL, on CALL, push the captured pc_o, then load the target.
REQ-009 SHALL, on RET, pop the top of stack into pc_o.
REQ-010 SHALL pulse br_done_o in COMMIT; br_taken_o=1 in the same cycle only if pc_o was redirected.
REQ-011 SHALL complete a request 2 cycles after acceptance (br_done_o in the 2nd cycle); the new pc_o is visible on the following cycle.
REQ-012 SHALL increment pc_o by one on pc_inc_i only in IDLE when br_req_i=0; pc_inc_i SHALL be dropped when br_req_i=1 or busy_o=1.
REQ-013 SHALL wrap pc_o from all-ones to zero with no flag.
REQ-014 SHALL, on CALL with stack_depth_o=STACK_DEPTH, not push, leave pc_o unchanged, set stack_overflow_o and complete with br_taken_o=0.
REQ-015 SHALL, on RET with stack_depth_o=0, leave pc_o unchanged, set stack_underflow_o and complete with br_taken_o=0.
REQ-016 SHALL keep a not-taken conditional branch as pc_o unchanged, br_done_o=1, br_taken_o=0.

Reset
REQ-017 SHALL, on reset assertion in any state, force:
- pc_o=0, FSM=IDLE, stack_depth_o=0.
- busy_o, br_done_o, br_taken_o, stack_overflow_o, stack_underflow_o = 0.
REQ-018 SHALL drop any in-flight request on reset; the stack contents need not be cleared.
REQ-019 SHALL clear the sticky error flags only by reset.

Structure
REQ-020 SHALL use br_op_t (JMP=0, JZ, JNZ, JN, JC, JNC, CALL, RET=7) defined in arch_defs_pkg, and ADDR_WIDTH taken from that package.
REQ-021 SHALL implement the return stack as one sub-module, return_stack (push, pop, data, depth, full, empty).
REQ-022 SHALL keep the condition decode combinational, inside pc_branch_unit.

Verification
REQ-023 SHALL cover: after reset, 3x pc_inc_i -> pc_o=0003.
REQ-024 SHALL cover: flags from CMP A=01 vs C=03 (Z=0, N=1, C=0); JC target 0040 -> br_taken_o=0, pc_o unchanged; JN target 0040 -> br_taken_o=1, pc_o=0040 two cycles after request.
REQ-025 SHALL cover: pc_o=0010, CALL 0100 -> pc_o=0100, depth=1; RET -> pc_o=0010, depth=0.
REQ-026 SHALL cover: 4 CALLs then a 5th CALL -> stack_overflow_o=1, pc_o unchanged, depth=4; RET on empty stack -> stack_underflow_o=1.
REQ-027 SHALL cover: pc_o=FFFF, pc_inc_i -> pc_o=0000; pc_inc_i with br_req_i in the same cycle -> increment dropped.
REQ-028 SHALL cover: reset asserted in EVAL -> pc_o=0000, busy_o=0 immediately, no br_done_o pulse.
